pu_dot_sequencer: RTL and testbench

Sequencer and accumulator that sits directly upstream of `processor_unit` and closes its accumulation loop. It streams element-pair beats from two fp32 vectors into one `processor_unit` instance and registers each beat's sum as the next beat's `previous` input. After `VEC_PAIRS` beats it presents the final dot product, plus an initial bias, on a valid/ready output.

---
 rtl/pu_pkg.sv | 13 +
 rtl/FloatingAddition.sv | 93 +++++++++
 rtl/fp_mult.sv | 55 +++++
 rtl/processor_unit.sv | 19 +
 rtl/pu_dot_sequencer.sv | 111 +++++++++++
 tb/tb_pu_dot_sequencer.sv | 240 ++++++++++++++++++++++++
 6 files changed

// File: rtl/pu_pkg.sv
// Shared types and fp32 constants for the processor-unit dot-product sequencer.
package pu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pu_seq_state_t;

    localparam logic [31:0] FP32_ZERO = 32'h00000000;
    localparam logic [31:0] FP32_ONE  = 32'h3F800000;

endpackage

// File: rtl/FloatingAddition.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// subnormal operands and results flushed to zero.
module FloatingAddition (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        swap;
    logic [31:0] big;
    logic [31:0] sml;
    logic [7:0]  shift;
    logic [26:0] mb;
    logic [26:0] ms;
    logic [26:0] al;
    logic [27:0] sum;
    logic [26:0] norm;
    logic [8:0]  exp_n;
    logic [4:0]  lz;
    logic        found;
    logic        uflow;
    logic        sub;
    logic [24:0] rnd;

    // Order by magnitude, align with sticky, add/subtract, normalise and round.
    always_comb begin
        swap  = (b[30:0] > a[30:0]);
        big   = swap ? b : a;
        sml   = swap ? a : b;
        sub   = (big[31] != sml[31]);
        shift = big[30:23] - sml[30:23];
        mb    = {1'b1, big[22:0], 3'b000};
        ms    = {1'b1, sml[22:0], 3'b000};
        al    = 27'd0;
        sum   = 28'd0;
        norm  = 27'd0;
        exp_n = {1'b0, big[30:23]};
        lz    = 5'd0;
        found = 1'b0;
        uflow = 1'b0;
        rnd   = 25'd0;
        y     = big;
        if (&big[30:23]) begin
            if ((|big[22:0]) || ((&sml[30:23]) && sub)) begin
                y = 32'h7FC00000;
            end else begin
                y = big;
            end
        end else if (big[30:23] == 8'd0) begin
            y = {big[31] & sml[31], 31'd0};
        end else if (sml[30:23] == 8'd0) begin
            y = big;
        end else begin
            if (shift > 8'd26) begin
                al = 27'd1;
            end else begin
                al = (ms >> shift) | {26'd0, |(ms & ~(27'h7FFFFFF << shift))};
            end
            if (!sub) begin
                sum   = {1'b0, mb} + {1'b0, al};
                found = 1'b1;
                if (sum[27]) begin
                    norm  = {sum[27:2], sum[1] | sum[0]};
                    exp_n = exp_n + 9'd1;
                end else begin
                    norm = sum[26:0];
                end
            end else begin
                sum = {1'b0, mb - al};
                for (int i = 26; i >= 0; i--) begin
                    if (!found && sum[i]) begin
                        lz    = 5'(26 - i);
                        found = 1'b1;
                    end else begin
                        found = found;
                    end
                end
                uflow = ({1'b0, big[30:23]} <= {4'd0, lz});
                norm  = sum[26:0] << lz;
                exp_n = exp_n - {4'd0, lz};
            end
            rnd   = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[1] | norm[0] | norm[3])};
            exp_n = exp_n + {8'd0, rnd[24]};
            if (!found || uflow) begin
                y = 32'd0;
            end else if (exp_n >= 9'd255) begin
                y = {big[31], 8'hFF, 23'd0};
            end else begin
                y = {big[31], exp_n[7:0], (rnd[24] ? rnd[23:1] : rnd[22:0])};
            end
        end
    end

endmodule

// File: rtl/fp_mult.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even,
// subnormal operands and results flushed to signed zero.
module fp_mult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        sign;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic [47:0] prod;
    logic [23:0] mant;
    logic        guard;
    logic        sticky;
    logic [24:0] rnd;
    logic [9:0]  esum;
    logic [9:0]  exp_n;

    // Special-value classification, mantissa product, normalise and round.
    always_comb begin
        sign   = a[31] ^ b[31];
        a_nan  = (&a[30:23]) & (|a[22:0]);
        b_nan  = (&b[30:23]) & (|b[22:0]);
        a_inf  = (&a[30:23]) & ~(|a[22:0]);
        b_inf  = (&b[30:23]) & ~(|b[22:0]);
        a_zero = ~(|a[30:23]);
        b_zero = ~(|b[30:23]);
        prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        esum   = {2'b00, a[30:23]} + {2'b00, b[30:23]};
        mant   = prod[47] ? prod[47:24] : prod[46:23];
        guard  = prod[47] ? prod[23] : prod[22];
        sticky = prod[47] ? (|prod[22:0]) : (|prod[21:0]);
        rnd    = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
        exp_n  = esum + {9'd0, prod[47]} + {9'd0, rnd[24]};
        y      = {sign, 31'd0};
        if (a_nan || b_nan) begin
            y = 32'h7FC00000;
        end else if (a_inf || b_inf) begin
            y = (a_zero || b_zero) ? 32'h7FC00000 : {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            y = {sign, 31'd0};
        end else if (exp_n <= 10'd127) begin
            y = {sign, 31'd0};
        end else if (exp_n >= 10'd382) begin
            y = {sign, 8'hFF, 23'd0};
        end else begin
            y = {sign, 8'(exp_n - 10'd127), (rnd[24] ? rnd[23:1] : rnd[22:0])};
        end
    end

endmodule

// File: rtl/processor_unit.sv
// One beat of a dot product: ((previous + array1_0*array2_0) + array1_1*array2_1).
module processor_unit (
    input  logic [31:0] previous,
    input  logic [31:0] array1_0,
    input  logic [31:0] array1_1,
    input  logic [31:0] array2_0,
    input  logic [31:0] array2_1,
    output logic [31:0] out
);
    logic [31:0] prod0;
    logic [31:0] prod1;
    logic [31:0] part;

    fp_mult u_mul0 (.a(array1_0), .b(array2_0), .y(prod0));
    FloatingAddition u_add0 (.a(previous), .b(prod0), .y(part));
    fp_mult u_mul1 (.a(array1_1), .b(array2_1), .y(prod1));
    FloatingAddition u_add1 (.a(part), .b(prod1), .y(out));

endmodule

// File: rtl/pu_dot_sequencer.sv
// Streams element-pair beats through one processor_unit, feeding each beat's
// sum back as the next beat's previous value; presents bias + dot product.
module pu_dot_sequencer
    import pu_pkg::*;
#(
    parameter int VEC_PAIRS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);
    localparam int CNT_W = $clog2(VEC_PAIRS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_PAIRS - 1);

    pu_seq_state_t    state;
    pu_seq_state_t    state_next;
    logic [31:0]      acc;
    logic [31:0]      acc_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      pu_out;

    processor_unit u_pu (
        .previous (acc),
        .array1_0 (a0),
        .array1_1 (a1),
        .array2_0 (b0),
        .array2_1 (b1),
        .out      (pu_out)
    );

    // State, accumulator and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= FP32_ZERO;
            cnt   <= {CNT_W{1'b0}};
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, accumulator update and handshake decode.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next   = bias;
                    cnt_next   = {CNT_W{1'b0}};
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    acc_next = pu_out;
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == LAST_BEAT) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end else begin
                    state_next = RUN;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                // Accepting the result and a new start in one cycle skips IDLE.
                if (out_ready && start) begin
                    acc_next   = bias;
                    cnt_next   = {CNT_W{1'b0}};
                    state_next = RUN;
                end else if (out_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result = acc;

endmodule

// File: tb/tb_pu_dot_sequencer.sv
// Directed bench for pu_dot_sequencer with an expected-result scoreboard.
module tb_pu_dot_sequencer;
    import pu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bias = 32'd0;
    logic [31:0] a0 = 32'd0;
    logic [31:0] a1 = 32'd0;
    logic [31:0] b0 = 32'd0;
    logic [31:0] b1 = 32'd0;

    logic        start2 = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        out_ready2 = 1'b0;
    logic        in_ready2;
    logic        out_valid2;
    logic        busy2;
    logic [31:0] result2;

    logic        start1 = 1'b0;
    logic        in_valid1 = 1'b0;
    logic        out_ready1 = 1'b0;
    logic        in_ready1;
    logic        out_valid1;
    logic        busy1;
    logic [31:0] result1;

    logic [31:0] exp_q[$];
    int          total = 0;
    int          passed = 0;

    // Beat operands in the order a0, b0, a1, b1.
    logic [31:0] beat_tab [2][4] = '{
        '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40800000},
        '{32'h3F000000, 32'h40000000, 32'h3F800000, 32'h3F800000}
    };

    localparam logic [31:0] FP32_13 = 32'h41500000;
    localparam logic [31:0] FP32_14 = 32'h41600000;

    always #5 clk = ~clk;

    pu_dot_sequencer #(.VEC_PAIRS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bias(bias),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .result(result2), .busy(busy2)
    );

    pu_dot_sequencer #(.VEC_PAIRS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bias(bias),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total = total + 1;
        assert (obs === expv) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic set_beat(input int k);
        a0 = beat_tab[k][0];
        b0 = beat_tab[k][1];
        a1 = beat_tab[k][2];
        b1 = beat_tab[k][3];
    endtask

    task automatic run_beats2(input bit gaps);
        for (int k = 0; k < 2; k++) begin
            if (gaps) begin
                int g = $urandom_range(1, 3);
                for (int j = 0; j < g; j++) begin
                    in_valid2 = 1'b0;
                    start2 = 1'($urandom_range(0, 1));
                    a0 = $urandom();
                    a1 = $urandom();
                    b0 = $urandom();
                    b1 = $urandom();
                    step();
                end
            end
            start2 = 1'b0;
            in_valid2 = 1'b1;
            set_beat(k);
            step();
        end
        in_valid2 = 1'b0;
    endtask

    task automatic wait_out2(input string tag);
        int n = 0;
        logic [31:0] expv;
        while (!out_valid2 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_valid"}, {31'd0, out_valid2}, 32'd1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check({tag, "_result"}, result2, expv);
    endtask

    initial begin
        // Reset
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready2}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid2}, 32'd0);
        check("rst_busy", {31'd0, busy2}, 32'd0);
        check("rst_result", result2, FP32_ZERO);
        check("rst_result1", result1, FP32_ZERO);

        // Basic dot product with cycle-exact latency
        bias = FP32_ZERO;
        start2 = 1'b1;
        exp_q.push_back(FP32_13);
        step();
        start2 = 1'b0;
        check("basic_run_ready", {31'd0, in_ready2}, 32'd1);
        check("basic_run_busy", {31'd0, busy2}, 32'd1);
        in_valid2 = 1'b1;
        set_beat(0);
        step();
        check("basic_c2_valid", {31'd0, out_valid2}, 32'd0);
        set_beat(1);
        step();
        in_valid2 = 1'b0;
        check("basic_c3_valid", {31'd0, out_valid2}, 32'd1);
        check("basic_c3_result", result2, exp_q.pop_front());
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        check("basic_idle_valid", {31'd0, out_valid2}, 32'd0);
        check("basic_idle_busy", {31'd0, busy2}, 32'd0);

        // Bias only, single beat of zeros
        bias = FP32_ONE;
        start1 = 1'b1;
        exp_q.push_back(FP32_ONE);
        step();
        start1 = 1'b0;
        a0 = 32'd0;
        a1 = 32'd0;
        b0 = 32'd0;
        b1 = 32'd0;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        check("bias_valid", {31'd0, out_valid1}, 32'd1);
        check("bias_result", result1, exp_q.pop_front());
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("bias_idle", {31'd0, busy1}, 32'd0);

        // Backpressure: input gaps, stray starts, held output
        bias = FP32_ZERO;
        start2 = 1'b1;
        exp_q.push_back(FP32_13);
        step();
        run_beats2(1'b1);
        wait_out2("bp");
        for (int j = 0; j < 5; j++) begin
            out_ready2 = 1'b0;
            start2 = (j % 2 == 0);
            step();
            check("bp_hold_valid", {31'd0, out_valid2}, 32'd1);
            check("bp_hold_result", result2, FP32_13);
        end
        start2 = 1'b0;
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        check("bp_idle_busy", {31'd0, busy2}, 32'd0);

        // Back-to-back: accept result and restart in the same cycle
        bias = FP32_ZERO;
        start2 = 1'b1;
        exp_q.push_back(FP32_13);
        step();
        run_beats2(1'b0);
        wait_out2("b2b_first");
        out_ready2 = 1'b1;
        start2 = 1'b1;
        bias = FP32_ONE;
        exp_q.push_back(FP32_14);
        step();
        start2 = 1'b0;
        out_ready2 = 1'b0;
        check("b2b_run_ready", {31'd0, in_ready2}, 32'd1);
        check("b2b_run_valid", {31'd0, out_valid2}, 32'd0);
        run_beats2(1'b0);
        wait_out2("b2b_second");
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;

        // Reset mid-run, then a fresh dot product
        bias = FP32_ZERO;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        in_valid2 = 1'b1;
        set_beat(0);
        step();
        in_valid2 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ready", {31'd0, in_ready2}, 32'd0);
        check("mid_rst_busy", {31'd0, busy2}, 32'd0);
        check("mid_rst_result", result2, FP32_ZERO);
        check("mid_rst_valid", {31'd0, out_valid2}, 32'd0);
        step();
        check("mid_rst_valid_hold", {31'd0, out_valid2}, 32'd0);
        start2 = 1'b1;
        exp_q.push_back(FP32_13);
        step();
        run_beats2(1'b0);
        wait_out2("post_rst");
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        check("end_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
